mul_reduce: RTL and testbench

MUL_REDUCE -- requirements
Module: mul_reduce

---
 rtl/mul_reduce.sv | 118 +++++++++++
 tb/tb_mul_reduce.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mul_reduce.sv
// ============================================================================
// mul_reduce : folds a 9-limb characteristic-2 product to 5 limbs with B^5 = B^2 + 1
// Revision   : 1.0 - initial release
// ============================================================================
`default_nettype none

module mul_reduce #(
   parameter int LIMB_W = 8
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [LIMB_W-1:0] s0,
   input  logic [LIMB_W-1:0] s1,
   input  logic [LIMB_W-1:0] s2,
   input  logic [LIMB_W-1:0] s3,
   input  logic [LIMB_W-1:0] s4,
   input  logic [LIMB_W-1:0] s5,
   input  logic [LIMB_W-1:0] s6,
   input  logic [LIMB_W-1:0] s7,
   input  logic [LIMB_W-1:0] s8,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [LIMB_W-1:0] r0,
   output logic [LIMB_W-1:0] r1,
   output logic [LIMB_W-1:0] r2,
   output logic [LIMB_W-1:0] r3,
   output logic [LIMB_W-1:0] r4,
   output logic              busy
);

   localparam logic [1:0] IDLE   = 2'd0;
   localparam logic [1:0] FOLD   = 2'd1;
   localparam logic [1:0] DONE   = 2'd2;
   localparam logic [3:0] K_TOP  = 4'd8;
   localparam logic [3:0] K_LAST = 4'd5;

   logic [1:0]        state;
   logic [3:0]        k;
   logic [LIMB_W-1:0] t      [0:8];
   logic [LIMB_W-1:0] s_in   [0:8];
   logic [LIMB_W-1:0] t_fold [0:8];

   assign s_in[0] = s0;
   assign s_in[1] = s1;
   assign s_in[2] = s2;
   assign s_in[3] = s3;
   assign s_in[4] = s4;
   assign s_in[5] = s5;
   assign s_in[6] = s6;
   assign s_in[7] = s7;
   assign s_in[8] = s8;

   // One fold of limb k: B^k = B^(k-3) + B^(k-5); k is always in 5..8 here.
   always_comb begin
      for (int i = 0; i < 9; i++) begin
         t_fold[i] = t[i];
      end
      for (int j = 5; j <= 8; j++) begin
         if (k == 4'(j)) begin
            t_fold[j-5] = t[j-5] ^ t[j];
            t_fold[j-3] = t[j-3] ^ t[j];
            t_fold[j]   = '0;
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= IDLE;
         k     <= K_TOP;
         for (int i = 0; i < 9; i++) begin
            t[i] <= '0;
         end
      end else begin
         case (state)
            IDLE: begin
               if (in_valid) begin
                  for (int i = 0; i < 9; i++) begin
                     t[i] <= s_in[i];
                  end
                  k     <= K_TOP;
                  state <= FOLD;
               end
            end
            FOLD: begin
               for (int i = 0; i < 9; i++) begin
                  t[i] <= t_fold[i];
               end
               k <= k - 4'd1;
               if (k == K_LAST) begin
                  state <= DONE;
               end
            end
            DONE: begin
               if (out_ready) begin
                  state <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign in_ready  = (state == IDLE);
   assign out_valid = (state == DONE);
   assign busy      = (state != IDLE);

   assign r0 = t[0];
   assign r1 = t[1];
   assign r2 = t[2];
   assign r3 = t[3];
   assign r4 = t[4];

endmodule

`default_nettype wire

// File: tb/tb_mul_reduce.sv
// ============================================================================
// tb_mul_reduce : randomized self-checking bench for mul_reduce against a polynomial model
// Revision      : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mul_reduce;

   logic            clk = 1'b0;
   logic            rst;
   logic            in_valid;
   logic            out_ready;
   logic [8:0][7:0] sv;
   logic            in_ready;
   logic            out_valid;
   logic            busy;
   logic [7:0]      r0, r1, r2, r3, r4;
   wire  [39:0]     rcat = {r4, r3, r2, r1, r0};

   int vectors = 0;
   int errors  = 0;

   always #5 clk = ~clk;

   mul_reduce #(.LIMB_W(8)) dut (
      .clk      (clk),
      .reset    (rst),
      .in_valid (in_valid),
      .in_ready (in_ready),
      .s0       (sv[0]),
      .s1       (sv[1]),
      .s2       (sv[2]),
      .s3       (sv[3]),
      .s4       (sv[4]),
      .s5       (sv[5]),
      .s6       (sv[6]),
      .s7       (sv[7]),
      .s8       (sv[8]),
      .out_valid(out_valid),
      .out_ready(out_ready),
      .r0       (r0),
      .r1       (r1),
      .r2       (r2),
      .r3       (r3),
      .r4       (r4),
      .busy     (busy)
   );

   // Polynomial in B with XOR coefficients, reduced from the top degree down.
   function automatic logic [39:0] model(input logic [8:0][7:0] p);
      logic [7:0] c [9];
      for (int i = 0; i < 9; i++) c[i] = p[i];
      for (int d = 8; d >= 5; d--) begin
         c[d-3] = c[d-3] ^ c[d];
         c[d-5] = c[d-5] ^ c[d];
         c[d]   = 8'h00;
      end
      return {c[4], c[3], c[2], c[1], c[0]};
   endfunction

   function automatic logic [8:0][7:0] rand_product();
      logic [8:0][7:0] p;
      for (int i = 0; i < 9; i++) p[i] = 8'($urandom);
      return p;
   endfunction

   // Accepts the product in sv (state must be IDLE), checks latency, holds
   // out_ready low for 'hold' cycles while perturbing inputs, then transfers.
   task automatic run_one(input string name, input int hold, output logic [39:0] got);
      logic [39:0] exp;
      exp       = model(sv);
      out_ready = 1'b0;
      in_valid  = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      vectors++;
      if (busy !== 1'b1 || in_ready !== 1'b0)
         begin errors++; $display("FAIL %s accept: busy=%b in_ready=%b, want 1/0", name, busy, in_ready); end
      for (int i = 1; i <= 3; i++) begin
         sv = rand_product();
         @(posedge clk); #1;
         vectors++;
         if (out_valid !== 1'b0)
            begin errors++; $display("FAIL %s early_valid edge %0d: out_valid=%b want 0", name, i, out_valid); end
      end
      @(posedge clk); #1;
      got = rcat;
      vectors++;
      if (out_valid !== 1'b1)
         begin errors++; $display("FAIL %s latency: out_valid=%b want 1", name, out_valid); end
      vectors++;
      if (rcat !== exp)
         begin errors++; $display("FAIL %s result: got %h want %h", name, rcat, exp); end
      for (int h = 0; h < hold; h++) begin
         in_valid = 1'($urandom);
         sv       = rand_product();
         @(posedge clk); #1;
         vectors++;
         if (out_valid !== 1'b1 || in_ready !== 1'b0 || rcat !== exp)
            begin errors++; $display("FAIL %s hold %0d: valid=%b ready=%b r=%h want 1/0/%h", name, h, out_valid, in_ready, rcat, exp); end
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      vectors++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0)
         begin errors++; $display("FAIL %s transfer: valid=%b ready=%b busy=%b want 0/1/0", name, out_valid, in_ready, busy); end
   endtask

   task automatic test_reset();
      vectors++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0 || rcat !== 40'h0)
         begin errors++; $display("FAIL reset_state: ready=%b valid=%b busy=%b r=%h want 1/0/0/0", in_ready, out_valid, busy, rcat); end
   endtask

   task automatic test_single_top_limb();
      logic [39:0] got;
      sv    = '0;
      sv[8] = 8'h01;
      run_one("s8_only", 0, got);
      vectors++;
      if (got !== 40'h00_01_01_00_01)
         begin errors++; $display("FAIL s8_only_const: got %h want 0001010001", got); end
   endtask

   task automatic test_s0_s5();
      logic [39:0] got;
      sv    = '0;
      sv[0] = 8'h0F;
      sv[5] = 8'hAA;
      run_one("s0_s5", 0, got);
      vectors++;
      if (got !== 40'h00_00_AA_00_A5)
         begin errors++; $display("FAIL s0_s5_const: got %h want 0000AA00A5", got); end
   endtask

   task automatic test_all_ones();
      logic [39:0] got;
      sv = '1;
      run_one("all_ff", 0, got);
   endtask

   task automatic test_hold();
      logic [39:0] got;
      sv = rand_product();
      run_one("hold10", 10, got);
   endtask

   task automatic test_reset_mid_fold();
      logic [39:0] got;
      sv        = rand_product();
      out_ready = 1'b1;
      in_valid  = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      @(posedge clk);
      @(posedge clk); #3;
      rst = 1'b1;
      #1;
      vectors++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0 || rcat !== 40'h0)
         begin errors++; $display("FAIL reset_mid_fold: ready=%b valid=%b busy=%b r=%h want 1/0/0/0", in_ready, out_valid, busy, rcat); end
      @(negedge clk);
      rst = 1'b0;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         vectors++;
         if (out_valid !== 1'b0)
            begin errors++; $display("FAIL reset_ghost cycle %0d: out_valid=%b want 0", i, out_valid); end
      end
      @(posedge clk); #1;
      out_ready = 1'b0;
      sv        = rand_product();
      run_one("after_reset", 0, got);
   endtask

   task automatic test_random();
      logic [39:0] got;
      for (int n = 0; n < 8; n++) begin
         sv = rand_product();
         run_one("random", int'($urandom_range(0, 3)), got);
      end
   endtask

   task automatic test_back_to_back();
      logic [39:0] q[$];
      int          last    = -1;
      int          results = 0;
      bit          took;
      in_valid  = 1'b1;
      out_ready = 1'b1;
      sv        = rand_product();
      for (int cyc = 0; cyc < 80 && results < 6; cyc++) begin
         @(negedge clk);
         took = 1'b0;
         if (out_valid) begin
            vectors++;
            if (q.size() == 0) begin
               errors++; $display("FAIL b2b_unexpected: r=%h with no product outstanding", rcat);
            end else begin
               if (rcat !== q[0])
                  begin errors++; $display("FAIL b2b_result: got %h want %h", rcat, q[0]); end
               void'(q.pop_front());
            end
            results++;
         end
         if (in_ready) begin
            if (last >= 0) begin
               vectors++;
               if (cyc - last != 6)
                  begin errors++; $display("FAIL b2b_spacing: got %0d want 6", cyc - last); end
            end
            last = cyc;
            q.push_back(model(sv));
            took = 1'b1;
         end
         @(posedge clk); #1;
         if (took) sv = rand_product();
      end
      in_valid = 1'b0;
      vectors++;
      if (results < 6)
         begin errors++; $display("FAIL b2b_timeout: got %0d results want 6", results); end
      for (int i = 0; i < 12 && !(in_ready && !out_valid); i++) @(posedge clk);
      #1;
      out_ready = 1'b0;
      vectors++;
      if (in_ready !== 1'b1)
         begin errors++; $display("FAIL b2b_drain: in_ready=%b want 1", in_ready); end
   endtask

   initial begin
      rst       = 1'b1;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      sv        = '0;
      #1;
      test_reset();
      #11;
      rst = 1'b0;
      @(posedge clk); #1;
      test_single_top_limb();
      test_s0_s5();
      test_all_ones();
      test_hold();
      test_reset_mid_fold();
      test_random();
      test_back_to_back();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

endmodule

`default_nettype wire
